// File: rtl/ones_pattern_tx_if.sv
// ones_pattern_tx_if: handshake and output bundle for ones_pattern_tx.
//   master : count source / downstream consumer side (drives load_valid, count)
//   slave  : pattern transmitter side (drives load_ready, sout, sout_valid, word, done, err)
//   load_valid/load_ready : count handshake
//   count                 : requested number of 1s (CW bits)
//   sout/sout_valid       : serial pattern, LSB first
//   word                  : parallel copy of the last accepted pattern
//   done                  : one-cycle pulse after the last serial bit
//   err                   : last accepted count was saturated to BITS
interface ones_pattern_tx_if #(
   parameter int unsigned BITS = 8,
   parameter int unsigned CW   = $clog2(BITS + 1)
);
   logic            load_valid;
   logic            load_ready;
   logic [CW-1:0]   count;
   logic            sout;
   logic            sout_valid;
   logic [BITS-1:0] word;
   logic            done;
   logic            err;

   modport master (
      output load_valid, count,
      input  load_ready, sout, sout_valid, word, done, err
   );

   modport slave (
      input  load_valid, count,
      output load_ready, sout, sout_valid, word, done, err
   );
endinterface

// File: rtl/ones_pattern_tx.sv
// ones_pattern_tx: accepts a ones count over a valid/ready handshake and serially emits a
// BITS-bit thermometer word (bits [c-1:0] set, LSB first), with the parallel word alongside.
// One word in flight; BITS+2 cycles per word (accept, BITS shift cycles, done cycle).
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : ones_pattern_tx_if slave (load_valid/load_ready/count in, sout/sout_valid/word/
//           done/err out)
module ones_pattern_tx #(
   parameter int unsigned BITS = 8,
   parameter int unsigned CW   = $clog2(BITS + 1)
) (
   input logic               clk,
   input logic               reset,
   ones_pattern_tx_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   c_q, c_d;
   logic [BITS-1:0] word_q, word_d;
   logic            err_q, err_d;
   logic            sout_q, sout_d;
   logic            sout_valid_q, sout_valid_d;
   logic            done_q, done_d;

   logic            over;
   logic [CW-1:0]   c_sat;

   assign over  = bus.count > CW'(BITS);
   assign c_sat = over ? CW'(BITS) : bus.count;

   // sout_q always holds the bit for the cycle after the edge, so it is computed
   // one index ahead of idx_q (idx_q names the bit currently on sout).
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      c_d          = c_q;
      word_d       = word_q;
      err_d        = err_q;
      sout_d       = 1'b0;
      sout_valid_d = 1'b0;
      done_d       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.load_valid) begin
               c_d   = c_sat;
               err_d = over;
               for (int unsigned i = 0; i < BITS; i++) begin
                  word_d[i] = CW'(i) < c_sat;
               end
               idx_d        = '0;
               sout_d       = c_sat != '0;
               sout_valid_d = 1'b1;
               state_d      = StShift;
            end
         end
         StShift: begin
            if (idx_q == CW'(BITS - 1)) begin
               done_d  = 1'b1;
               idx_d   = '0;
               state_d = StDone;
            end else begin
               idx_d        = idx_q + CW'(1);
               sout_d       = (idx_q + CW'(1)) < c_q;
               sout_valid_d = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         c_q          <= '0;
         word_q       <= '0;
         err_q        <= 1'b0;
         sout_q       <= 1'b0;
         sout_valid_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         c_q          <= c_d;
         word_q       <= word_d;
         err_q        <= err_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
         done_q       <= done_d;
      end
   end

   assign bus.load_ready = state_q == StIdle;
   assign bus.sout       = sout_q;
   assign bus.sout_valid = sout_valid_q;
   assign bus.word       = word_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_ones_pattern_tx.sv
// tb_ones_pattern_tx: scoreboard bench for ones_pattern_tx. The driver pushes the expected
// word per accepted count; a monitor checks every cycle against a timing model derived from
// the accept cycle and pops/compares the word on each done pulse.
module tb_ones_pattern_tx;
   localparam int unsigned BITS = 8;
   localparam int unsigned CW   = $clog2(BITS + 1);

   logic clk   = 1'b0;
   logic reset = 1'b1;

   ones_pattern_tx_if #(.BITS(BITS), .CW(CW)) bus ();

   ones_pattern_tx #(.BITS(BITS), .CW(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int              c;
      logic [BITS-1:0] w;
      logic            e;
      int              acc;
   } exp_t;

   exp_t q[$];

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference model state: accept cycle of the current word and the words/errs visible
   // before and after that accept.
   bit              have_acc = 1'b0;
   int              acc      = 0;
   int              cur_c    = 0;
   logic [BITS-1:0] cur_w    = '0;
   logic [BITS-1:0] prev_w   = '0;
   logic            cur_e    = 1'b0;
   logic            prev_e   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
   endtask

   function automatic int sat(input int c);
      return (c > int'(BITS)) ? int'(BITS) : c;
   endfunction

   function automatic logic [BITS-1:0] ref_word(input int c);
      longint v;
      v = (64'd1 << sat(c)) - 1;
      return v[BITS-1:0];
   endfunction

   initial begin : monitor
      logic [BITS-1:0] col;
      int              ncol;
      int              m;
      bit              sv, dn, rd, so;
      exp_t            e;
      col  = '0;
      ncol = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            col  = '0;
            ncol = 0;
         end else begin
            m  = cyc;
            sv = have_acc && m >= acc && m < acc + int'(BITS);
            dn = have_acc && m == acc + int'(BITS);
            rd = !(have_acc && m >= acc && m <= acc + int'(BITS));
            so = sv && (m - acc) < cur_c;
            check("load_ready", 32'(bus.load_ready), 32'(rd));
            check("sout_valid", 32'(bus.sout_valid), 32'(sv));
            check("done", 32'(bus.done), 32'(dn));
            check("sout", 32'(bus.sout), 32'(so));
            check("word_hold", 32'(bus.word), 32'((have_acc && m >= acc) ? cur_w : prev_w));
            check("err_hold", 32'(bus.err), 32'((have_acc && m >= acc) ? cur_e : prev_e));
            if (bus.sout_valid && ncol < int'(BITS)) begin
               col[ncol] = bus.sout;
               ncol++;
            end
            if (bus.done) begin
               if (q.size() == 0) begin
                  total_cnt++;
                  $display("FAIL done_unexpected at cycle %0d: got done=1, expected no word", m);
               end else begin
                  e = q.pop_front();
                  check("serial_word", 32'(col), 32'(e.w));
                  check("par_word", 32'(bus.word), 32'(e.w));
                  check("err", 32'(bus.err), 32'(e.c > int'(BITS)));
                  check("popcount", 32'($countones(bus.word)), 32'(sat(e.c)));
                  check("bit_count", 32'(ncol), 32'(BITS));
                  check("done_latency", 32'(m - e.acc), 32'(BITS));
               end
               col  = '0;
               ncol = 0;
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset          = 1'b1;
      bus.load_valid = 1'b0;
      have_acc       = 1'b0;
      cur_c          = 0;
      cur_w          = '0;
      prev_w         = '0;
      cur_e          = 1'b0;
      prev_e         = 1'b0;
      q.delete();
      #1;
      check("rst_load_ready", 32'(bus.load_ready), 32'd1);
      check("rst_sout", 32'(bus.sout), 32'd0);
      check("rst_sout_valid", 32'(bus.sout_valid), 32'd0);
      check("rst_word", 32'(bus.word), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Present count c until accepted; keep=1 leaves load_valid high with a junk count
   // while the word is in flight, which the DUT must ignore.
   task automatic send(input int c, input bit keep);
      int n;
      n = 0;
      @(negedge clk);
      bus.count      = CW'(c);
      bus.load_valid = 1'b1;
      while (!bus.load_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!bus.load_ready) begin
         total_cnt++;
         $display("FAIL accept_timeout: count %0d not accepted after %0d cycles", c, n);
         bus.load_valid = 1'b0;
         return;
      end
      prev_w   = cur_w;
      prev_e   = cur_e;
      cur_c    = sat(c);
      cur_w    = ref_word(c);
      cur_e    = c > int'(BITS);
      acc      = cyc + 1;
      have_acc = 1'b1;
      q.push_back('{c: c, w: ref_word(c), e: c > int'(BITS), acc: cyc + 1});
      @(posedge clk);
      #1;
      if (keep) bus.count = CW'($urandom_range(0, 15));
      else bus.load_valid = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int c;
      bit keep;
      bus.load_valid = 1'b0;
      bus.count      = '0;
      do_reset();

      send(3, 1'b0);
      send(0, 1'b0);
      send(8, 1'b0);
      send(12, 1'b0);
      // back-to-back with load_valid held high
      send(5, 1'b1);
      send(2, 1'b0);

      // abort a word in its 4th shift cycle
      send(7, 1'b0);
      repeat (3) @(negedge clk);
      do_reset();
      repeat (BITS + 3) @(negedge clk);
      send(6, 1'b0);

      for (int k = 0; k <= int'(BITS); k++) send(k, 1'b0);

      for (int i = 0; i < 60; i++) begin
         c    = int'($urandom_range(0, 15));
         keep = 1'($urandom_range(0, 1));
         send(c, keep);
         if (!keep) repeat ($urandom_range(0, 12)) @(negedge clk);
      end
      bus.load_valid = 1'b0;

      repeat (BITS + 4) @(negedge clk);
      check("queue_empty", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
